// File: rtl/kf_pic_pkg.sv
// Shared constants and priority helpers for the KF interrupt controller family.
// Helpers operate on LEVELS_MAX-bit vectors; only the low n bits are meaningful
// and n must be a power of two so that modulo reduces to a mask.
package kf_pic_pkg;

   localparam int unsigned LEVELS_DEFAULT = 8;
   localparam int unsigned LEVELS_MAX     = 32;

   // OCW2 command field {R,SL,EOI}
   localparam logic [2:0] EOI_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] EOI_NONSPEC      = 3'b001;
   localparam logic [2:0] EOI_NOP          = 3'b010;
   localparam logic [2:0] EOI_SPEC         = 3'b011;
   localparam logic [2:0] EOI_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] EOI_ROT_NONSPEC  = 3'b101;
   localparam logic [2:0] EOI_SET_PRIO     = 3'b110;
   localparam logic [2:0] EOI_ROT_SPEC     = 3'b111;

   // result[i] = v[(i + amt) mod n]
   function automatic logic [LEVELS_MAX-1:0] rotate_right(input logic [LEVELS_MAX-1:0] v,
                                                         input int unsigned amt,
                                                         input int unsigned n);
      logic [LEVELS_MAX-1:0] r;
      int unsigned           j;
      r = '0;
      for (int unsigned i = 0; i < LEVELS_MAX; i++) begin
         j = (i + amt) & (n - 1);
         if (i < n) r[i[4:0]] = v[j[4:0]];
      end
      return r;
   endfunction

   // result[(i + amt) mod n] = v[i]
   function automatic logic [LEVELS_MAX-1:0] rotate_left(input logic [LEVELS_MAX-1:0] v,
                                                        input int unsigned amt,
                                                        input int unsigned n);
      logic [LEVELS_MAX-1:0] r;
      int unsigned           j;
      r = '0;
      for (int unsigned i = 0; i < LEVELS_MAX; i++) begin
         j = (i + amt) & (n - 1);
         if (i < n) r[j[4:0]] = v[i[4:0]];
      end
      return r;
   endfunction

   // One-hot of the highest-priority request; level ptr+1 is highest, ptr lowest.
   function automatic logic [LEVELS_MAX-1:0] resolve_priority(input logic [LEVELS_MAX-1:0] req,
                                                             input int unsigned ptr,
                                                             input int unsigned n);
      logic [LEVELS_MAX-1:0] rot;
      logic [LEVELS_MAX-1:0] pick;
      int unsigned           amt;
      amt  = (ptr + 1) & (n - 1);
      rot  = rotate_right(req, amt, n);
      pick = rot & (~rot + LEVELS_MAX'(1));
      return rotate_left(pick, amt, n);
   endfunction

   // Index of the set bit in a one-hot vector (0 when empty).
   function automatic int unsigned onehot_index(input logic [LEVELS_MAX-1:0] v);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < LEVELS_MAX; i++) begin
         if (v[i[4:0]]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/kf_in_service_tracker_if.sv
// Bus bundle between the ack sequencer / command interface and the ISR tracker.
// master: drives ack, EOI command and mode inputs; slave: the tracker.
interface kf_in_service_tracker_if #(
   parameter int unsigned LEVELS = kf_pic_pkg::LEVELS_DEFAULT
);
   localparam int unsigned LEVEL_W = $clog2(LEVELS);

   logic               ack_valid;
   logic [LEVEL_W-1:0] ack_level;
   logic               auto_eoi;
   logic               special_mask_mode;
   logic [LEVELS-1:0]  interrupt_mask;
   logic               eoi_valid;
   logic [2:0]         eoi_cmd;
   logic [LEVEL_W-1:0] eoi_level;
   logic [LEVELS-1:0]  in_service;
   logic [LEVELS-1:0]  highest_in_service;
   logic [LEVEL_W-1:0] priority_pointer;
   logic               rotate_in_aeoi;
   logic               eoi_miss;

   modport master (
      output ack_valid, ack_level, auto_eoi, special_mask_mode, interrupt_mask,
             eoi_valid, eoi_cmd, eoi_level,
      input  in_service, highest_in_service, priority_pointer, rotate_in_aeoi, eoi_miss
   );

   modport slave (
      input  ack_valid, ack_level, auto_eoi, special_mask_mode, interrupt_mask,
             eoi_valid, eoi_cmd, eoi_level,
      output in_service, highest_in_service, priority_pointer, rotate_in_aeoi, eoi_miss
   );

endinterface

// File: rtl/kf_priority_resolver.sv
// Combinational rotating-priority picker.
// req: request vector; ptr: lowest-priority level; grant_c: one-hot winner or 0.
module kf_priority_resolver
   import kf_pic_pkg::*;
#(
   parameter int unsigned LEVELS = LEVELS_DEFAULT,
   localparam int unsigned LEVEL_W = $clog2(LEVELS)
) (
   input  logic [LEVELS-1:0]  req,
   input  logic [LEVEL_W-1:0] ptr,
   output logic [LEVELS-1:0]  grant_c
);

   assign grant_c = LEVELS'(resolve_priority(LEVELS_MAX'(req), 32'(ptr), LEVELS));

endmodule

// File: rtl/kf_in_service_tracker.sv
// In-service register, EOI/rotation command decode, priority pointer and AEOI.
// clock/reset_n: clock and synchronous active-low reset.
// bus (slave): ack/EOI/mode inputs in, ISR, highest in-service, pointer,
//              rotate-in-AEOI flag and eoi_miss pulse out (all registered).
module kf_in_service_tracker
   import kf_pic_pkg::*;
#(
   parameter int unsigned LEVELS = LEVELS_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset_n,
   kf_in_service_tracker_if.slave bus
);

   localparam int unsigned LEVEL_W = $clog2(LEVELS);

   logic [LEVELS-1:0]  isr_q, isr_d;
   logic [LEVELS-1:0]  high_q;
   logic [LEVEL_W-1:0] ptr_q, ptr_d;
   logic               raeoi_q, raeoi_d;
   logic               miss_q, miss_d;
   logic               pend_valid_q;
   logic [LEVEL_W-1:0] pend_level_q;

   logic [LEVELS-1:0]  mask_eff_c;
   logic [LEVELS-1:0]  eligible_c;
   logic [LEVELS-1:0]  ns_target_c;
   logic [LEVELS-1:0]  high_req_c;
   logic [LEVELS-1:0]  high_c;
   logic [LEVELS-1:0]  clear_c;
   logic [LEVELS-1:0]  eoi_onehot_c;

   // Masked levels only drop out of priority while special mask mode is on
   assign mask_eff_c = bus.special_mask_mode ? bus.interrupt_mask : '0;
   assign eligible_c = isr_q & ~mask_eff_c;
   assign high_req_c = isr_d & ~mask_eff_c;

   kf_priority_resolver #(.LEVELS(LEVELS)) u_eoi_target (
      .req     (eligible_c),
      .ptr     (ptr_q),
      .grant_c (ns_target_c)
   );

   kf_priority_resolver #(.LEVELS(LEVELS)) u_highest (
      .req     (high_req_c),
      .ptr     (ptr_d),
      .grant_c (high_c)
   );

   // Next-state: clears against the current ISR first, then the ack set wins
   always_comb begin
      clear_c      = '0;
      ptr_d        = ptr_q;
      raeoi_d      = raeoi_q;
      miss_d       = 1'b0;
      eoi_onehot_c = LEVELS'(1) << bus.eoi_level;

      // Automatic EOI one cycle after an AEOI acknowledge; an EOI rotate below overrides
      if (pend_valid_q) begin
         clear_c = LEVELS'(1) << pend_level_q;
         if (raeoi_q) ptr_d = pend_level_q;
      end

      if (bus.eoi_valid) begin
         case (bus.eoi_cmd)
            EOI_NONSPEC, EOI_ROT_NONSPEC: begin
               if (ns_target_c == '0) begin
                  miss_d = 1'b1;
               end else begin
                  clear_c = clear_c | ns_target_c;
                  if (bus.eoi_cmd == EOI_ROT_NONSPEC)
                     ptr_d = LEVEL_W'(onehot_index(LEVELS_MAX'(ns_target_c)));
               end
            end
            EOI_SPEC, EOI_ROT_SPEC: begin
               if (isr_q[bus.eoi_level]) clear_c = clear_c | eoi_onehot_c;
               else                      miss_d  = 1'b1;
               // Rotation on specific EOI applies even when the bit was already clear
               if (bus.eoi_cmd == EOI_ROT_SPEC) ptr_d = bus.eoi_level;
            end
            EOI_SET_PRIO:     ptr_d   = bus.eoi_level;
            EOI_SET_ROT_AEOI: raeoi_d = 1'b1;
            EOI_CLR_ROT_AEOI: raeoi_d = 1'b0;
            default: ;
         endcase
      end

      isr_d = (isr_q & ~clear_c) | (bus.ack_valid ? (LEVELS'(1) << bus.ack_level) : '0);
   end

   // State registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         isr_q        <= '0;
         high_q       <= '0;
         ptr_q        <= LEVEL_W'(LEVELS - 1);
         raeoi_q      <= 1'b0;
         miss_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_level_q <= '0;
      end else begin
         isr_q        <= isr_d;
         high_q       <= high_c;
         ptr_q        <= ptr_d;
         raeoi_q      <= raeoi_d;
         miss_q       <= miss_d;
         pend_valid_q <= bus.ack_valid & bus.auto_eoi;
         pend_level_q <= bus.ack_level;
      end
   end

   assign bus.in_service         = isr_q;
   assign bus.highest_in_service = high_q;
   assign bus.priority_pointer   = ptr_q;
   assign bus.rotate_in_aeoi     = raeoi_q;
   assign bus.eoi_miss           = miss_q;

endmodule

// File: tb/tb_kf_in_service_tracker.sv
// Self-checking bench: directed scenarios plus random traffic on an 8-level
// tracker against a behavioural model, and a directed 16-level scenario.
module tb_kf_in_service_tracker;

   localparam int unsigned N8  = 8;
   localparam int unsigned N16 = 16;

   logic clk = 1'b0;
   logic rst8_n;
   logic rst16_n;

   always #5 clk = ~clk;

   kf_in_service_tracker_if #(.LEVELS(N8))  bus8 ();
   kf_in_service_tracker_if #(.LEVELS(N16)) bus16 ();

   kf_in_service_tracker #(.LEVELS(N8)) dut8 (
      .clock   (clk),
      .reset_n (rst8_n),
      .bus     (bus8.slave)
   );

   kf_in_service_tracker #(.LEVELS(N16)) dut16 (
      .clock   (clk),
      .reset_n (rst16_n),
      .bus     (bus16.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference state for the 8-level instance
   logic [31:0] m_isr;
   logic [31:0] m_high;
   int          m_ptr;
   bit          m_raeoi;
   bit          m_miss;
   bit          m_pv;
   int          m_pl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Highest-priority set level: walk from ptr+1 around to ptr; -1 if none
   function automatic int top_level(input logic [31:0] v, input int ptr, input int n);
      logic [4:0] l;
      for (int k = 1; k <= n; k++) begin
         l = 5'((ptr + k) % n);
         if (v[l]) return int'(l);
      end
      return -1;
   endfunction

   task automatic step8();
      logic [31:0] isr_n, eff, elig, high_n;
      int          ptr_n, h, cmd, lvl;
      bit          ra_n, miss_n, pv_n;
      int          pl_n;
      if (!rst8_n) begin
         isr_n = '0; high_n = '0; ptr_n = N8 - 1; ra_n = 0; miss_n = 0; pv_n = 0; pl_n = 0;
      end else begin
         eff    = bus8.special_mask_mode ? 32'(bus8.interrupt_mask) : 32'd0;
         elig   = m_isr & ~eff;
         isr_n  = m_isr;
         ptr_n  = m_ptr;
         ra_n   = m_raeoi;
         miss_n = 0;
         cmd    = int'(bus8.eoi_cmd);
         lvl    = int'(bus8.eoi_level);
         if (m_pv) begin
            isr_n[5'(m_pl)] = 1'b0;
            if (m_raeoi) ptr_n = m_pl;
         end
         if (bus8.eoi_valid) begin
            case (cmd)
               1, 5: begin
                  h = top_level(elig, m_ptr, N8);
                  if (h < 0) miss_n = 1;
                  else begin
                     isr_n[5'(h)] = 1'b0;
                     if (cmd == 5) ptr_n = h;
                  end
               end
               3, 7: begin
                  if (m_isr[5'(lvl)]) isr_n[5'(lvl)] = 1'b0;
                  else                miss_n = 1;
                  if (cmd == 7) ptr_n = lvl;
               end
               6: ptr_n = lvl;
               4: ra_n = 1;
               0: ra_n = 0;
               default: ;
            endcase
         end
         if (bus8.ack_valid) isr_n[5'(bus8.ack_level)] = 1'b1;
         pv_n   = bus8.ack_valid && bus8.auto_eoi;
         pl_n   = int'(bus8.ack_level);
         h      = top_level(isr_n & ~eff, ptr_n, N8);
         high_n = (h < 0) ? 32'd0 : (32'd1 << h);
      end
      @(posedge clk);
      #1;
      m_isr = isr_n; m_high = high_n; m_ptr = ptr_n; m_raeoi = ra_n;
      m_miss = miss_n; m_pv = pv_n; m_pl = pl_n;
      chk("isr8",   32'(bus8.in_service),         m_isr);
      chk("high8",  32'(bus8.highest_in_service), m_high);
      chk("ptr8",   32'(bus8.priority_pointer),   32'(m_ptr));
      chk("raeoi8", 32'(bus8.rotate_in_aeoi),     32'(m_raeoi));
      chk("miss8",  32'(bus8.eoi_miss),           32'(m_miss));
   endtask

   task automatic ack8(input int l);
      bus8.ack_valid = 1'b1;
      bus8.ack_level = 3'(l);
      step8();
      bus8.ack_valid = 1'b0;
   endtask

   task automatic eoi8(input int cmd, input int l);
      bus8.eoi_valid = 1'b1;
      bus8.eoi_cmd   = 3'(cmd);
      bus8.eoi_level = 3'(l);
      step8();
      bus8.eoi_valid = 1'b0;
   endtask

   task automatic reset8();
      rst8_n = 1'b0;
      step8();
      rst8_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst8_n  = 1'b0;
      rst16_n = 1'b0;
      bus8.ack_valid = 1'b0; bus8.ack_level = '0; bus8.auto_eoi = 1'b0;
      bus8.special_mask_mode = 1'b0; bus8.interrupt_mask = '0;
      bus8.eoi_valid = 1'b0; bus8.eoi_cmd = '0; bus8.eoi_level = '0;
      bus16.ack_valid = 1'b0; bus16.ack_level = '0; bus16.auto_eoi = 1'b0;
      bus16.special_mask_mode = 1'b0; bus16.interrupt_mask = '0;
      bus16.eoi_valid = 1'b0; bus16.eoi_cmd = '0; bus16.eoi_level = '0;
      m_isr = '0; m_high = '0; m_ptr = N8 - 1; m_raeoi = 0; m_miss = 0; m_pv = 0; m_pl = 0;

      // Reset values
      step8();
      step8();
      rst8_n = 1'b1;
      chk("rst_isr",   32'(bus8.in_service), 32'h0);
      chk("rst_high",  32'(bus8.highest_in_service), 32'h0);
      chk("rst_ptr",   32'(bus8.priority_pointer), 32'd7);
      chk("rst_raeoi", 32'(bus8.rotate_in_aeoi), 32'd0);
      chk("rst_miss",  32'(bus8.eoi_miss), 32'd0);

      // Ack 3 then 5, then non-specific EOI
      ack8(3);
      ack8(5);
      chk("ack_isr",  32'(bus8.in_service), 32'h28);
      chk("ack_high", 32'(bus8.highest_in_service), 32'h08);
      chk("ack_ptr",  32'(bus8.priority_pointer), 32'd7);
      eoi8(1, 0);
      chk("nseoi_isr",  32'(bus8.in_service), 32'h20);
      chk("nseoi_high", 32'(bus8.highest_in_service), 32'h20);

      // Rotate on non-specific EOI
      ack8(3);
      eoi8(5, 0);
      chk("rot_isr",  32'(bus8.in_service), 32'h20);
      chk("rot_ptr",  32'(bus8.priority_pointer), 32'd3);
      chk("rot_high", 32'(bus8.highest_in_service), 32'h20);
      ack8(4);
      chk("rot_ack4_high", 32'(bus8.highest_in_service), 32'h10);

      // AEOI with rotate-in-AEOI
      reset8();
      eoi8(4, 0);
      chk("raeoi_set", 32'(bus8.rotate_in_aeoi), 32'd1);
      bus8.auto_eoi = 1'b1;
      ack8(6);
      chk("aeoi_isr1", 32'(bus8.in_service), 32'h40);
      bus8.auto_eoi = 1'b0;
      step8();
      chk("aeoi_isr2", 32'(bus8.in_service), 32'h00);
      chk("aeoi_ptr",  32'(bus8.priority_pointer), 32'd6);

      // Special mask mode
      reset8();
      bus8.special_mask_mode = 1'b1;
      bus8.interrupt_mask    = 8'h04;
      ack8(1);
      ack8(2);
      chk("smm_isr",  32'(bus8.in_service), 32'h06);
      chk("smm_high", 32'(bus8.highest_in_service), 32'h02);
      eoi8(1, 0);
      chk("smm_eoi1_isr",  32'(bus8.in_service), 32'h04);
      chk("smm_eoi1_miss", 32'(bus8.eoi_miss), 32'd0);
      eoi8(1, 0);
      chk("smm_eoi2_isr",  32'(bus8.in_service), 32'h04);
      chk("smm_eoi2_miss", 32'(bus8.eoi_miss), 32'd1);
      step8();
      chk("smm_miss_drop", 32'(bus8.eoi_miss), 32'd0);
      bus8.special_mask_mode = 1'b0;
      bus8.interrupt_mask    = 8'h00;

      // Same-cycle ack and specific EOI on one bit; specific EOI on empty level
      reset8();
      ack8(2);
      bus8.ack_valid = 1'b1; bus8.ack_level = 3'd2;
      bus8.eoi_valid = 1'b1; bus8.eoi_cmd = 3'b011; bus8.eoi_level = 3'd2;
      step8();
      bus8.ack_valid = 1'b0; bus8.eoi_valid = 1'b0;
      chk("same_isr", 32'(bus8.in_service), 32'h04);
      eoi8(3, 7);
      chk("spec_miss",     32'(bus8.eoi_miss), 32'd1);
      chk("spec_miss_isr", 32'(bus8.in_service), 32'h04);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst8_n         = ($urandom_range(0, 149) != 0);
         bus8.ack_valid = ($urandom_range(0, 2) == 0);
         bus8.ack_level = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) bus8.auto_eoi = ~bus8.auto_eoi;
         if ($urandom_range(0, 9) == 0)  bus8.special_mask_mode = ~bus8.special_mask_mode;
         if ($urandom_range(0, 9) == 0)  bus8.interrupt_mask = 8'($urandom);
         bus8.eoi_valid = ($urandom_range(0, 2) == 0);
         bus8.eoi_cmd   = 3'($urandom_range(0, 7));
         bus8.eoi_level = 3'($urandom_range(0, 7));
         step8();
      end
      rst8_n = 1'b1;
      bus8.ack_valid = 1'b0;
      bus8.eoi_valid = 1'b0;
      step8();

      // 16 levels: set priority 9, ack 10 and 3, then reset mid-sequence
      tick();
      rst16_n = 1'b1;
      bus16.eoi_valid = 1'b1; bus16.eoi_cmd = 3'b110; bus16.eoi_level = 4'd9;
      tick();
      bus16.eoi_valid = 1'b0;
      bus16.ack_valid = 1'b1; bus16.ack_level = 4'd10;
      tick();
      bus16.ack_level = 4'd3;
      tick();
      bus16.ack_valid = 1'b0;
      chk("l16_high", 32'(bus16.highest_in_service), 32'h0400);
      chk("l16_isr",  32'(bus16.in_service), 32'h0408);
      chk("l16_ptr",  32'(bus16.priority_pointer), 32'd9);
      rst16_n = 1'b0;
      bus16.ack_valid = 1'b1; bus16.ack_level = 4'd5;
      tick();
      rst16_n = 1'b1;
      bus16.ack_valid = 1'b0;
      chk("l16_rst_isr",   32'(bus16.in_service), 32'h0);
      chk("l16_rst_high",  32'(bus16.highest_in_service), 32'h0);
      chk("l16_rst_ptr",   32'(bus16.priority_pointer), 32'd15);
      chk("l16_rst_raeoi", 32'(bus16.rotate_in_aeoi), 32'd0);
      chk("l16_rst_miss",  32'(bus16.eoi_miss), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kf_in_service_tracker.md
# kf_in_service_tracker

Parametrised in-service tracker for the KF interrupt controller family: holds the in-service register (ISR) for `LEVELS` interrupt levels, decodes OCW2-style end-of-interrupt/rotation commands, owns the priority pointer, and supports automatic EOI with optional rotate-in-AEOI. It sits between the interrupt-acknowledge sequencer (set side) and the command/bus interface (EOI side), and feeds `highest_in_service` to the request-priority comparator.

## Interface
Parameters:
- `LEVELS`, 8, number of interrupt levels; power of two, 2..32
- `LEVEL_W`, $clog2(LEVELS), derived localparam, level index width

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `ack_valid`  in  1  one-cycle pulse: level `ack_level` enters service
- `ack_level`  in  LEVEL_W  acknowledged level index
- `auto_eoi`  in  1  AEOI mode (static ICW4 bit)
- `special_mask_mode`  in  1  SMM enable
- `interrupt_mask`  in  LEVELS  IMR; excluded from priority only while SMM=1
- `eoi_valid`  in  1  one-cycle command strobe
- `eoi_cmd`  in  3  {R,SL,EOI}
- `eoi_level`  in  LEVEL_W  level for specific commands
- `in_service`  out  LEVELS  ISR
- `highest_in_service`  out  LEVELS  one-hot highest-priority in-service level, or 0
- `priority_pointer`  out  LEVEL_W  lowest-priority level
- `rotate_in_aeoi`  out  1  rotate-in-AEOI flag
- `eoi_miss`  out  1  one-cycle pulse: EOI targeted nothing

## Operation
- Priority order: level `priority_pointer+1` (mod LEVELS) highest, `priority_pointer` lowest.
- `eoi_cmd` decode, when `eoi_valid`: 001 non-specific EOI; 011 specific EOI on `eoi_level`; 101 rotate on non-specific EOI (pointer <= cleared level); 111 rotate on specific EOI (pointer <= `eoi_level`); 110 set priority (pointer <= `eoi_level`, ISR unchanged); 100 set `rotate_in_aeoi`; 000 clear `rotate_in_aeoi`; 010 no-op.
- Non-specific EOI clears the highest-priority ISR bit under current pointer, ignoring bits with `interrupt_mask`=1 when SMM=1. No eligible bit: ISR/pointer unchanged, `eoi_miss`=1.
- Specific EOI on clear bit: no change, `eoi_miss`=1; rotate-on-specific still updates pointer.
- `ack_valid`, `auto_eoi`=0: ISR[`ack_level`] set.
- `ack_valid`, `auto_eoi`=1: ISR bit set, cleared automatically one cycle later via internal AEOI-pending register (valid + level); if `rotate_in_aeoi`, pointer <= that level at the clear.
- Simultaneous events, one cycle: clears (EOI, AEOI pending) evaluated on current ISR first, then ack set; set wins on same bit. Rotate from EOI command takes precedence over AEOI rotate.
- `highest_in_service` computed from next ISR, next pointer and SMM-masked bits; registered.

## Timing
- Reset (`reset_n`=0 at edge): ISR=0, `highest_in_service`=0, pointer=LEVELS-1, `rotate_in_aeoi`=0, `eoi_miss`=0, AEOI pending cleared. Reset mid-AEOI discards pending clear.
- Latency 1: ack/EOI at edge N visible on `in_service`, `highest_in_service`, pointer after N; always mutually consistent.
- AEOI bit visible exactly one cycle.
- `eoi_miss` registered, high one cycle after offending strobe.
- Pointer wrap: modulo LEVELS; pointer=LEVELS-1 means level 0 highest.

## Structure
- Package `kf_pic_pkg`: `EOI_*` command encodings, default LEVELS, generic `rotate_left`/`rotate_right`/`resolve_priority` functions over LEVELS bits.
- Sub-module `kf_priority_resolver` (LEVELS param): rotate right by pointer+1, one-hot lowest-index pick, rotate back; combinational, instanced twice (EOI target, highest_in_service).

## Test plan
- Reset, LEVELS=8: ack 3 then 5 -> ISR=0x28, highest=0x08, pointer=7; NS-EOI -> ISR=0x20, highest=0x20.
- Rotate NS-EOI with ISR=0x28 -> ISR=0x20, pointer=3, level 4 highest; ack 4 -> highest=0x10.
- AEOI + rotate_in_aeoi set (cmd 100), ack 6 -> ISR=0x40 one cycle, then 0x00, pointer=6.
- SMM=1, mask=0x04, ISR=0x06 -> highest=0x02; NS-EOI clears bit 1; second NS-EOI -> ISR=0x04 unchanged, `eoi_miss` pulse.
- Same cycle: ack 2 + specific EOI 2 with ISR bit 2 set -> bit 2 remains set; specific EOI 7 on empty -> `eoi_miss`.
- LEVELS=16: set priority 9, ack 10 and 3 -> highest=0x0400; reset_n low mid-sequence -> all reset values next cycle.
